pipe_io_ctrl: RTL and testbench
===============================

Name: pipe_io_ctrl

Overview:
Parametrised memory-mapped I/O controller for the pipelined CPU's MEM stage. It generalises the fixed two-in/two-out port connector to NUM_IN debounced input ports and NUM_OUT output registers. Each output register drives hex 7-segment digits. A sticky change-status register is cleared on read, and read data is registered. It sits beside data memory and is selected by the MEM-stage address decode.

Parameters:
NUM_IN, 4, number of input ports (switch groups), 1..8
IN_W, 4, bits per input port, 1..32
NUM_OUT, 4, number of output registers, 1..8
OUT_W, 8, bits per output register, multiple of 4, 4..32
DEB_CYCLES, 16, consecutive stable cycles required before a debounced input updates, >=1

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high reset
io_addr  in  8  byte address within the I/O window; bits [1:0] ignored
io_we  in  1  write strobe, one cycle per write
io_re  in  1  read strobe, one cycle per read
io_wdata  in  32  write data
io_rdata  out  32  registered read data
io_rvalid  out  1  high the cycle after io_re
in_raw  in  NUM_IN*IN_W  asynchronous switch inputs; port i occupies [i*IN_W +: IN_W]
seg  out  NUM_OUT*(OUT_W/4)*7  active-low segments {g..a} per digit; digit 0 is the LSB nibble of OUT_0
irq  out  1  interrupt request (see Optional Feature)

Behaviour:
- Address map (word offsets):
  - 0x80+4*i: IN_i, read-only, zero-extended debounced value.
  - 0xC0+4*j: OUT_j, read/write, low OUT_W bits.
  - 0xF0: STATUS, bit i = input i changed.
  - 0xF4: CTRL, bit0 = display enable.
  - 0xF8: IRQ_MASK.
  - Unmapped or out-of-range index: reads 0, writes ignored.
- Reset values: OUT_j=0, STATUS=0, CTRL=1, IRQ_MASK=0, io_rdata=0, io_rvalid=0, irq=0, all debounce counters=0. Debounced values are 0, and the sync flops are 0.
- Input path: 2-flop synchroniser, then a per-port debouncer.
  - The candidate value is the synced input; the counter restarts whenever the synced input differs from the previous synced sample.
  - When the counter reaches DEB_CYCLES-1 with an unchanged sample and the candidate differs from the debounced value, the debounced value updates on the next edge and STATUS[i] sets.
  - Total latency from a stable in_raw change to an IN_i update is 2+DEB_CYCLES cycles.
- Read: on io_re, io_rdata/io_rvalid load on the next edge; io_rvalid is a one-cycle pulse. With no io_re, io_rdata holds its last value.
- Write: on io_we, the register updates on the next edge. For a simultaneous io_we and io_re to the same address, io_rdata returns the pre-write value.
- STATUS clear-on-read:
  - A read of 0xF0 clears the bits that were returned, on the same edge that loads io_rdata.
  - If a new change sets bit i on that same edge, bit i stays 1 (set wins).
  - Writes to STATUS are ignored.
- Display:
  - CTRL[0]=1: each nibble is hex-decoded (0-F, standard patterns, active-low).
  - CTRL[0]=0: all seg outputs are 1 (blank).
  - seg is registered: one cycle after the OUT/CTRL update.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); any pending read is lost, and io_rvalid=0.

Optional Feature:
PIPE_IO_IRQ_EN.
- Defined: irq is a register equal to |(STATUS & IRQ_MASK[NUM_IN-1:0]), updated every cycle. IRQ_MASK is read/write. irq drops the cycle after the STATUS read that clears the masked bits, unless a new change sets one of them.
- Undefined: irq is tied 0, IRQ_MASK reads 0, and writes to it are ignored.

Decomposition:
- Shared package pipe_io_pkg holds:
  - Address offset constants (IN_BASE=8'h80, OUT_BASE=8'hC0, STATUS_ADDR=8'hF0, CTRL_ADDR=8'hF4, IRQ_MASK_ADDR=8'hF8).
  - The hex-to-7-segment function.
  - The DEB counter width function (clog2).
- Sub-module pipe_io_debounce (synchroniser, counter, debounced value, change pulse; parameter IN_W, DEB_CYCLES) is instantiated NUM_IN times via generate.

Test Plan:
1. Reset: assert reset mid-run -> seg all 1s except digits showing 0 (7'b1000000), io_rdata=0, STATUS=0, CTRL reads 1.
2. Debounce (DEB_CYCLES=16): in_raw port 1 = 4'hA held 18 cycles -> IN_1 reads 0xA only after cycle 18, and STATUS bit1=1. A glitch shorter than 16 cycles causes no change.
3. Write OUT_2=8'h3F, then read 0xC8 -> io_rvalid pulses one cycle later with 0x3F; the digits for OUT_2 show "3","F" one cycle after the write. Write CTRL=0 -> all seg=1.
4. Clear-on-read race: the STATUS read coincides with a new port-0 change -> returned bit0=0 or 1 per its pre-edge value, and bit0=1 afterwards. Other returned bits are cleared.
5. Same-cycle write/read of OUT_0 (old 0x11, new 0x22) -> io_rdata=0x11, and a subsequent read gives 0x22. Unmapped 0x40 reads 0.
6. PIPE_IO_IRQ_EN: IRQ_MASK=0x4, port-2 change -> irq rises one cycle after the STATUS set and falls after the STATUS read. A port-1 change never raises irq.

Source files
------------

// File: rtl/pipe_io_pkg.sv
// pipe_io_pkg: shared constants and helpers for the pipe_io_ctrl I/O block.
//   - I/O window byte offsets (IN, OUT, STATUS, CTRL, IRQ_MASK)
//   - hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}
//   - debounce counter width helper
package pipe_io_pkg;

    localparam logic [7:0] IN_BASE       = 8'h80;
    localparam logic [7:0] OUT_BASE      = 8'hC0;
    localparam logic [7:0] STATUS_ADDR   = 8'hF0;
    localparam logic [7:0] CTRL_ADDR     = 8'hF4;
    localparam logic [7:0] IRQ_MASK_ADDR = 8'hF8;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segment pattern, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        unique case (nib)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            4'hF: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

    // Counter must reach cycles-1; keep at least one bit for cycles == 1.
    function automatic int unsigned deb_cnt_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/pipe_io_debounce.sv
// pipe_io_debounce: one input port's 2-flop synchroniser plus debouncer.
// Ports:
//   i_clock, i_reset  clock, asynchronous active-high reset
//   i_raw             asynchronous switch input (IN_W bits)
//   o_value           debounced value
//   o_change          high in the cycle whose rising edge updates o_value
module pipe_io_debounce
    import pipe_io_pkg::*;
#(
    parameter int unsigned IN_W       = 4,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [IN_W-1:0] i_raw,
    output logic [IN_W-1:0] o_value,
    output logic            o_change
);

    localparam int unsigned       CNT_W    = deb_cnt_w(DEB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [IN_W-1:0]  r_sync1;
    logic [IN_W-1:0]  r_sync2;
    logic [IN_W-1:0]  r_value;
    logic [CNT_W-1:0] r_cnt;
    logic             w_stable;
    logic             w_update;

    // r_sync2 is the candidate; r_sync1 is the sample that follows it, so a
    // mismatch restarts the count one edge earlier and the end-to-end latency
    // of a clean change is 2 + DEB_CYCLES edges.
    assign w_stable = (r_sync1 == r_sync2);
    assign w_update = w_stable && (r_cnt == CNT_LAST) && (r_sync2 != r_value);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_value <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_stable) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_update) begin
                r_value <= r_sync2;
            end
        end
    end

    assign o_value  = r_value;
    assign o_change = w_update;

endmodule

// File: rtl/pipe_io_ctrl.sv
// pipe_io_ctrl: memory-mapped I/O controller for the CPU MEM stage.
// NUM_IN debounced input ports, NUM_OUT output registers shown on hex 7-seg
// digits, clear-on-read change STATUS, CTRL (display enable), registered reads.
// Optional interrupt logic is built when macro PIPE_IO_IRQ_EN is defined.
// Ports:
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_io_addr/we/re/wdata     bus request (addr bits [1:0] ignored)
//   o_io_rdata, o_io_rvalid   registered read data, one-cycle valid pulse
//   i_in_raw                  raw switch inputs, port i at [i*IN_W +: IN_W]
//   o_seg                     active-low {g..a} per digit, digit 0 = OUT_0[3:0]
//   o_irq                     interrupt request (0 without PIPE_IO_IRQ_EN)
module pipe_io_ctrl
    import pipe_io_pkg::*;
#(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned IN_W       = 4,
    parameter int unsigned NUM_OUT    = 4,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic [7:0]                   i_io_addr,
    input  logic                         i_io_we,
    input  logic                         i_io_re,
    input  logic [31:0]                  i_io_wdata,
    output logic [31:0]                  o_io_rdata,
    output logic                         o_io_rvalid,
    input  logic [NUM_IN*IN_W-1:0]       i_in_raw,
    output logic [NUM_OUT*(OUT_W/4)*7-1:0] o_seg,
    output logic                         o_irq
);

    localparam int unsigned DIG_PER_OUT = OUT_W / 4;
    localparam int unsigned NUM_DIG     = NUM_OUT * DIG_PER_OUT;
    localparam int unsigned SEG_W       = NUM_DIG * 7;
    localparam logic [SEG_W-1:0] SEG_RESET = {NUM_DIG{SEG_ZERO}};

    logic [NUM_IN-1:0][IN_W-1:0]   w_deb;
    logic [NUM_IN-1:0]             w_change;
    logic [NUM_OUT-1:0][OUT_W-1:0] r_out;
    logic [NUM_IN-1:0]             r_status;
    logic                          r_ctrl;
    logic [31:0]                   r_rdata;
    logic                          r_rvalid;
    logic [SEG_W-1:0]              r_seg;
    logic [SEG_W-1:0]              w_seg_next;
    logic [31:0]                   w_rd_data;

    // Address decode on word offsets.
    logic [3:0] w_idx;
    logic       w_in_sel;
    logic       w_out_sel;
    logic       w_status_sel;
    logic       w_ctrl_sel;
    logic       w_mask_sel;
    logic       w_rd_status;

    assign w_idx        = i_io_addr[5:2];
    assign w_in_sel     = (i_io_addr[7:6] == IN_BASE[7:6]);
    assign w_out_sel    = (i_io_addr[7:6] == OUT_BASE[7:6]) &&
                          (i_io_addr[7:4] != STATUS_ADDR[7:4]);
    assign w_status_sel = (i_io_addr[7:2] == STATUS_ADDR[7:2]);
    assign w_ctrl_sel   = (i_io_addr[7:2] == CTRL_ADDR[7:2]);
    assign w_mask_sel   = (i_io_addr[7:2] == IRQ_MASK_ADDR[7:2]);
    assign w_rd_status  = i_io_re && w_status_sel;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_deb
        pipe_io_debounce #(
            .IN_W       (IN_W),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .i_clock  (i_clock),
            .i_reset  (i_reset),
            .i_raw    (i_in_raw[gi*IN_W +: IN_W]),
            .o_value  (w_deb[gi]),
            .o_change (w_change[gi])
        );
    end

`ifdef PIPE_IO_IRQ_EN
    logic [NUM_IN-1:0] r_irq_mask;
    logic              r_irq;
`endif

    // Read mux; unmapped and out-of-range indices return zero.
    always_comb begin
        w_rd_data = '0;
        if (w_in_sel) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (w_idx == 4'(i)) w_rd_data[IN_W-1:0] = w_deb[i];
            end
        end else if (w_out_sel) begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (w_idx == 4'(j)) w_rd_data[OUT_W-1:0] = r_out[j];
            end
        end else if (w_status_sel) begin
            w_rd_data[NUM_IN-1:0] = r_status;
        end else if (w_ctrl_sel) begin
            w_rd_data[0] = r_ctrl;
        end
`ifdef PIPE_IO_IRQ_EN
        else if (w_mask_sel) begin
            w_rd_data[NUM_IN-1:0] = r_irq_mask;
        end
`endif
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_out    <= '0;
            r_status <= '0;
            r_ctrl   <= 1'b1;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= i_io_re;
            if (i_io_re) r_rdata <= w_rd_data;
            // Clear exactly what this read returned; a change landing on the
            // same edge still sets its bit.
            if (w_rd_status) r_status <= w_change;
            else             r_status <= r_status | w_change;
            if (i_io_we) begin
                if (w_out_sel) begin
                    for (int j = 0; j < NUM_OUT; j++) begin
                        if (w_idx == 4'(j)) r_out[j] <= i_io_wdata[OUT_W-1:0];
                    end
                end
                if (w_ctrl_sel) r_ctrl <= i_io_wdata[0];
            end
        end
    end

    always_comb begin
        w_seg_next = '1;
        if (r_ctrl) begin
            for (int j = 0; j < NUM_OUT; j++) begin
                for (int d = 0; d < DIG_PER_OUT; d++) begin
                    w_seg_next[(j*DIG_PER_OUT + d)*7 +: 7] = hex_to_seg(r_out[j][d*4 +: 4]);
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_seg <= SEG_RESET;
        else         r_seg <= w_seg_next;
    end

`ifdef PIPE_IO_IRQ_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_irq_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (i_io_we && w_mask_sel) r_irq_mask <= i_io_wdata[NUM_IN-1:0];
            r_irq <= |(r_status & r_irq_mask);
        end
    end
    assign o_irq = r_irq;
`else
    assign o_irq = 1'b0;
`endif

    // Bits of the bus that carry no information here.
    logic w_unused;
    assign w_unused = ^{i_io_addr[1:0], i_io_wdata, w_mask_sel};

    assign o_io_rdata  = r_rdata;
    assign o_io_rvalid = r_rvalid;
    assign o_seg       = r_seg;

endmodule

// File: tb/tb_pipe_io_ctrl.sv
// Directed bench for pipe_io_ctrl with default parameters (4x4 in, 4x8 out,
// DEB_CYCLES=16). Register-level behaviour is table driven; debounce, seg
// timing, clear-on-read race, irq and mid-run reset are hand sequences.
module tb_pipe_io_ctrl;

`ifdef PIPE_IO_IRQ_EN
    localparam logic        IRQ_ON  = 1'b1;
    localparam logic [31:0] MASK_RB = 32'h5;
`else
    localparam logic        IRQ_ON  = 1'b0;
    localparam logic [31:0] MASK_RB = 32'h0;
`endif

    logic        clock;
    logic        reset;
    logic [7:0]  io_addr;
    logic        io_we;
    logic        io_re;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        io_rvalid;
    logic [15:0] in_raw;
    logic [55:0] seg;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    pipe_io_ctrl #(
        .NUM_IN     (4),
        .IN_W       (4),
        .NUM_OUT    (4),
        .OUT_W      (8),
        .DEB_CYCLES (16)
    ) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_io_addr   (io_addr),
        .i_io_we     (io_we),
        .i_io_re     (io_re),
        .i_io_wdata  (io_wdata),
        .o_io_rdata  (io_rdata),
        .o_io_rvalid (io_rvalid),
        .i_in_raw    (in_raw),
        .o_seg       (seg),
        .o_irq       (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;   // expected io_rdata after the edge (held value if no read)
    } vec_t;

    function automatic vec_t mk(input logic we, input logic re, input logic [7:0] a,
                                input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.we = we; v.re = re; v.addr = a; v.wdata = d; v.exp = e;
        return v;
    endfunction

    function automatic logic [6:0] pat(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h40; 4'h1: p = 7'h79; 4'h2: p = 7'h24; 4'h3: p = 7'h30;
            4'h4: p = 7'h19; 4'h5: p = 7'h12; 4'h6: p = 7'h02; 4'h7: p = 7'h78;
            4'h8: p = 7'h00; 4'h9: p = 7'h10; 4'hA: p = 7'h08; 4'hB: p = 7'h03;
            4'hC: p = 7'h46; 4'hD: p = 7'h21; 4'hE: p = 7'h06; default: p = 7'h0E;
        endcase
        return p;
    endfunction

    // outs = {OUT_3, OUT_2, OUT_1, OUT_0}
    function automatic logic [55:0] exp_seg(input logic [31:0] outs, input logic en);
        logic [55:0] r;
        for (int k = 0; k < 8; k++) r[k*7 +: 7] = en ? pat(outs[k*4 +: 4]) : 7'h7F;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        io_we = 1'b1; io_addr = a; io_wdata = d;
        @(negedge clock);
        io_we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
        io_re = 1'b1; io_addr = a;
        @(negedge clock);
        io_re = 1'b0;
        check(name, 64'(io_rdata), 64'(exp));
        check({name, "_rvalid"}, 64'(io_rvalid), 64'd1);
    endtask

    vec_t vecs[26];

    initial begin
        reset = 1'b0; io_addr = '0; io_we = 1'b0; io_re = 1'b0; io_wdata = '0; in_raw = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_seg", 64'(seg), 64'(exp_seg(32'h0, 1'b1)));
        check("rst_rdata", 64'(io_rdata), 64'd0);
        check("rst_rvalid", 64'(io_rvalid), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // we, re, addr, wdata, expected rdata
        vecs[0]  = mk(0, 1, 8'hF0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 1, 8'hF4, 32'h0,        32'h1);
        vecs[2]  = mk(0, 1, 8'hF8, 32'h0,        32'h0);
        vecs[3]  = mk(1, 0, 8'hC0, 32'h11,       32'h0);
        vecs[4]  = mk(1, 0, 8'hC4, 32'hAB,       32'h0);
        vecs[5]  = mk(0, 1, 8'hC0, 32'h0,        32'h11);
        vecs[6]  = mk(0, 1, 8'hC4, 32'h0,        32'hAB);
        vecs[7]  = mk(1, 1, 8'hC0, 32'h22,       32'h11);  // same-cycle: old value
        vecs[8]  = mk(0, 1, 8'hC0, 32'h0,        32'h22);
        vecs[9]  = mk(1, 0, 8'hCC, 32'hFFFFFF5A, 32'h22);
        vecs[10] = mk(0, 1, 8'hCC, 32'h0,        32'h5A);
        vecs[11] = mk(1, 0, 8'hD0, 32'h77,       32'h5A);  // OUT_4 does not exist
        vecs[12] = mk(0, 1, 8'hC1, 32'h0,        32'h22);  // low addr bits ignored
        vecs[13] = mk(0, 1, 8'hD0, 32'h0,        32'h0);
        vecs[14] = mk(0, 1, 8'hC4, 32'h0,        32'hAB);
        vecs[15] = mk(0, 1, 8'h40, 32'h0,        32'h0);
        vecs[16] = mk(1, 0, 8'hF0, 32'hF,        32'h0);   // STATUS not writable
        vecs[17] = mk(0, 1, 8'hF0, 32'h0,        32'h0);
        vecs[18] = mk(0, 1, 8'h84, 32'h0,        32'h0);
        vecs[19] = mk(0, 1, 8'hC4, 32'h0,        32'hAB);
        vecs[20] = mk(0, 1, 8'h90, 32'h0,        32'h0);   // IN_4 does not exist
        vecs[21] = mk(1, 0, 8'hF8, 32'h5,        32'h0);
        vecs[22] = mk(0, 1, 8'hF8, 32'h0,        MASK_RB);
        vecs[23] = mk(1, 0, 8'hF8, 32'h0,        MASK_RB);
        vecs[24] = mk(0, 1, 8'hCC, 32'h0,        32'h5A);
        vecs[25] = mk(0, 0, 8'hC0, 32'h0,        32'h5A);  // idle: rdata holds

        for (int i = 0; i < 26; i++) begin
            io_we = vecs[i].we; io_re = vecs[i].re;
            io_addr = vecs[i].addr; io_wdata = vecs[i].wdata;
            @(negedge clock);
            io_we = 1'b0; io_re = 1'b0;
            check($sformatf("vec%0d_rdata", i), 64'(io_rdata), 64'(vecs[i].exp));
            check($sformatf("vec%0d_rvalid", i), 64'(io_rvalid), 64'(vecs[i].re));
        end

        // Display: seg follows OUT one edge later, CTRL=0 blanks.
        wr(8'hC8, 32'h3F);
        check("seg_before", 64'(seg), 64'(exp_seg(32'h5A00AB22, 1'b1)));
        @(negedge clock);
        check("seg_after", 64'(seg), 64'(exp_seg(32'h5A3FAB22, 1'b1)));
        check("seg_digit4_F", 64'(seg[34:28]), 64'(7'b0001110));
        check("seg_digit5_3", 64'(seg[41:35]), 64'(7'b0110000));
        rd("rd_out2", 8'hC8, 32'h3F);
        @(negedge clock);
        check("rvalid_pulse_end", 64'(io_rvalid), 64'd0);
        wr(8'hF4, 32'h0);
        check("seg_blank_lag", 64'(seg), 64'(exp_seg(32'h5A3FAB22, 1'b1)));
        @(negedge clock);
        check("seg_blank", 64'(seg), {8'h0, {56{1'b1}}});
        wr(8'hF4, 32'h1);
        @(negedge clock);
        check("seg_unblank", 64'(seg), 64'(exp_seg(32'h5A3FAB22, 1'b1)));

        // Debounce latency: port 1 -> 0xA; IN_1 must change on edge 18.
        in_raw[7:4] = 4'hA;
        io_re = 1'b1; io_addr = 8'h84;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            check($sformatf("deb_in1_k%0d", k), 64'(io_rdata), (k >= 19) ? 64'hA : 64'h0);
        end
        io_re = 1'b0;
        rd("deb_status", 8'hF0, 32'h2);
        rd("deb_status_clr", 8'hF0, 32'h0);

        // Glitch shorter than DEB_CYCLES is ignored.
        in_raw[7:4] = 4'h5;
        repeat (10) @(negedge clock);
        in_raw[7:4] = 4'hA;
        repeat (30) @(negedge clock);
        rd("glitch_in1", 8'h84, 32'hA);
        rd("glitch_status", 8'hF0, 32'h0);

        // Clear-on-read race: STATUS read on the edge port 0's change lands.
        in_raw[15:12] = 4'h7;
        repeat (25) @(negedge clock);
        in_raw[3:0] = 4'h3;
        repeat (17) @(negedge clock);
        rd("race_returned", 8'hF0, 32'h8);
        rd("race_after", 8'hF0, 32'h1);
        rd("race_cleared", 8'hF0, 32'h0);
        rd("race_in0", 8'h80, 32'h3);

        // Interrupt: mask port 2 only.
        wr(8'hF8, 32'h4);
        in_raw[11:8] = 4'h9;
        repeat (18) @(negedge clock);
        check("irq_not_yet", 64'(irq), 64'd0);
        @(negedge clock);
        check("irq_rise", 64'(irq), 64'(IRQ_ON));
        rd("irq_status", 8'hF0, 32'h4);
        check("irq_hold", 64'(irq), 64'(IRQ_ON));
        @(negedge clock);
        check("irq_fall", 64'(irq), 64'd0);
        in_raw[7:4] = 4'h0;
        repeat (25) @(negedge clock);
        check("irq_port1_masked", 64'(irq), 64'd0);
        rd("irq_port1_status", 8'hF0, 32'h2);

        // Reset in the middle of a read: read is dropped, state returns to reset.
        rd("pre_rst_out2", 8'hC8, 32'h3F);
        io_re = 1'b1; io_addr = 8'hC8;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rvalid", 64'(io_rvalid), 64'd0);
        check("mid_rst_rdata", 64'(io_rdata), 64'd0);
        check("mid_rst_seg", 64'(seg), 64'(exp_seg(32'h0, 1'b1)));
        check("mid_rst_irq", 64'(irq), 64'd0);
        @(negedge clock);
        io_re = 1'b0;
        check("mid_rst_rvalid2", 64'(io_rvalid), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        rd("post_rst_ctrl", 8'hF4, 32'h1);
        rd("post_rst_status", 8'hF0, 32'h0);
        rd("post_rst_out2", 8'hC8, 32'h0);
        rd("post_rst_mask", 8'hF8, 32'h0);
        rd("post_rst_in0", 8'h80, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
